multi_edge_detector: RTL and testbench
======================================

Name: multi_edge_detector

Overview:
- Multi-channel, parametrised successor to the single-channel falling-edge pulse stretcher.
- Each channel synchronises an asynchronous input and detects rising, falling or both edges, selected at runtime.
- Each detected edge produces an output pulse of programmable length, with optional retrigger.
- Per-channel sticky event flags can be polled and cleared by software-facing logic, e.g. an HPS/GPIO status register block.

Parameters:
- CHANNELS, 4, number of independent input channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel before edge detection (2..4).
- CNT_W, 4, width of the pulse-length counter and the extend input.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- signal_in  input  CHANNELS  asynchronous level inputs, one bit per channel.
- edge_mode  input  2  edge select for all channels: 00 none, 01 rising, 10 falling, 11 both.
- extend  input  CNT_W  pulse length in clk cycles; 0 means no pulse is generated.
- retrigger  input  1  1: an edge during an active pulse reloads the counter; 0: such edges are ignored for pulse purposes.
- flag_clear  input  CHANNELS  per-channel clear of the sticky flag, sampled each cycle.
- pulse_out  output  CHANNELS  stretched edge pulse per channel.
- pulse_any  output  1  OR of all pulse_out bits.
- edge_flag  output  CHANNELS  sticky per-channel "edge seen" flag.

Behaviour:
- Reset:
  - Asynchronous assertion of rst_n=0 clears all synchroniser flops, previous-sample regs, counters and flags.
  - pulse_out=0, pulse_any=0, edge_flag=0 while in reset.
  - Deassertion is assumed synchronous to clk at board level; no internal reset synchroniser.
- Synchroniser: signal_in[i] passes through SYNC_STAGES flops; s_i denotes the last stage.
- Previous sample: p_i <= s_i every cycle.
- Edge terms, evaluated combinationally from s_i and p_i:
  - rise_i = s_i & ~p_i.
  - fall_i = ~s_i & p_i.
  - ev_i = (edge_mode[0] & rise_i) | (edge_mode[1] & fall_i).
- Counter, per channel, CNT_W bits, updated on the clock edge:
  - ev_i=1 and cnt_i==0: cnt_i <= extend.
  - ev_i=1, cnt_i!=0 and retrigger=1: cnt_i <= extend.
  - ev_i=1, cnt_i!=0 and retrigger=0: cnt_i <= cnt_i-1.
  - ev_i=0 and cnt_i!=0: cnt_i <= cnt_i-1.
  - ev_i=0 and cnt_i==0: hold at 0. No wrap below 0.
- Outputs:
  - pulse_out[i] = (cnt_i != 0), combinational from the counter register; glitch-free.
  - pulse_any = |pulse_out.
- Latency:
  - An input transition stable before clk edge 1 gives pulse_out high after edge SYNC_STAGES+1 (3 edges with defaults).
  - The pulse stays high for exactly extend cycles when no retrigger occurs.
  - extend is sampled only at the load cycle; later changes do not affect an active pulse.
- Sticky flag:
  - edge_flag[i] <= (edge_flag[i] & ~flag_clear[i]) | ev_i.
  - The flag sets on the same edge the counter loads.
  - Simultaneous ev_i and flag_clear[i]: flag ends set (edge wins).
  - The flag sets even when extend=0 or the edge is ignored because retrigger=0.
- edge_mode=00: no events, no flags; active pulses still count down to 0.
- edge_mode is sampled each cycle; a change affects edge evaluation from the next clock edge. No events are synthesised by the mode change itself.
- Reset start-up:
  - An input held high through reset release appears as a rising edge SYNC_STAGES+1 cycles after release, since p resets to 0.
  - An input held low through reset release produces no event.
- Input pulses shorter than one clk period may be missed; this is accepted and not flagged.
- Channels are fully independent apart from the shared edge_mode, extend and retrigger inputs.
- Reset mid-pulse clears the pulse immediately and asynchronously.

Test Plan:
- Defaults, edge_mode=10, extend=3: signal_in[0] 1->0 -> pulse_out[0] high on edges 3,4,5 after the change, low on edge 6; edge_flag[0]=1; other channels stay 0.
- edge_mode=11, extend=2: signal_in[1] 0->1, held 10 cycles, then 1->0 -> two separate 2-cycle pulses; edge_flag[1]=1.
- retrigger=1, extend=4, second rising edge 2 cycles into the pulse -> pulse_out continuous for 2+4=6 cycles. Same stimulus with retrigger=0 -> pulse length 4.
- extend=0, edge_mode=01, rising edge on channel 2 -> pulse_out[2] never asserts, edge_flag[2]=1. Then flag_clear[2]=1 for 1 cycle -> edge_flag[2]=0 on the next edge. Clear coincident with a new event -> flag stays 1.
- rst_n driven low mid-pulse, with cnt=5 on channel 0 -> pulse_out and edge_flag go 0 without a clock edge. After release with signal_in[3] held high and edge_mode=01 -> rising event on channel 3 at edge 3.
- edge_mode=00 with random toggling on all channels for 100 cycles -> no pulse_out, edge_flag stays 0. Switch edge_mode to 01 -> next rising edge detected normally.

Source files
------------

// File: rtl/multi_edge_detector.sv
// Per-channel synchroniser, runtime-selected edge detector, pulse stretcher and sticky flag.
// Pulse rises SYNC_STAGES+1 clocks after an input transition and is never backpressured.
module multi_edge_detector #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] signal_in,
  input  logic [1:0]          edge_mode,
  input  logic [CNT_W-1:0]    extend,
  input  logic                retrigger,
  input  logic [CHANNELS-1:0] flag_clear,
  output logic [CHANNELS-1:0] pulse_out,
  output logic                pulse_any,
  output logic [CHANNELS-1:0] edge_flag
);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] prev_q;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CHANNELS-1:0] sync_out;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= signal_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // prev_q resets to 0, so an input held high through reset shows up as a rising edge.
  always_comb begin
    rise = sync_out & ~prev_q;
    fall = ~sync_out & prev_q;
    ev   = ({CHANNELS{edge_mode[0]}} & rise) | ({CHANNELS{edge_mode[1]}} & fall);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      edge_flag <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      prev_q    <= sync_out;
      edge_flag <= (edge_flag & ~flag_clear) | ev;
      for (int i = 0; i < CHANNELS; i++) begin
        // Without retrigger, an edge inside an active pulse just lets the countdown continue.
        if (ev[i] && ((cnt_q[i] == '0) || retrigger)) begin
          cnt_q[i] <= extend;
        end else if (cnt_q[i] != '0) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    pulse_out = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pulse_out[i] = (cnt_q[i] != '0);
    end
  end

  assign pulse_any = |pulse_out;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Scoreboard bench for multi_edge_detector: expected pulse/flag vectors are queued per cycle as stimulus is driven.
module tb_multi_edge_detector;

  logic       clk;
  logic       rst_n;
  logic [3:0] signal_in;
  logic [1:0] edge_mode;
  logic [3:0] extend;
  logic       retrigger;
  logic [3:0] flag_clear;
  logic [3:0] pulse_out;
  logic       pulse_any;
  logic [3:0] edge_flag;

  typedef struct packed {
    logic [3:0] pulse;
    logic [3:0] flag;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;

  multi_edge_detector #(.CHANNELS(4), .SYNC_STAGES(2), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .signal_in  (signal_in),
    .edge_mode  (edge_mode),
    .extend     (extend),
    .retrigger  (retrigger),
    .flag_clear (flag_clear),
    .pulse_out  (pulse_out),
    .pulse_any  (pulse_any),
    .edge_flag  (edge_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    flag_clear = 4'hF;
    tick();
    flag_clear = 4'h0;
  endtask

  task automatic push_exp(input logic [3:0] p, input logic [3:0] f);
    exp_t e;
    e.pulse = p;
    e.flag  = f;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (pulse_out !== 4'h0 || pulse_any !== 1'b0 || edge_flag !== 4'h0) begin
      bad++;
      $display("FAIL reset_state pulse=%b any=%b flag=%b expected all zero", pulse_out, pulse_any, edge_flag);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) tick();
    total++;
    if (pulse_out !== 4'h0 || edge_flag !== 4'h0) begin
      bad++;
      $display("FAIL reset_low_inputs pulse=%b flag=%b expected 0000/0000", pulse_out, edge_flag);
    end
  endtask

  task automatic test_falling();
    exp_t e;
    edge_mode = 2'b10;
    extend    = 4'd3;
    retrigger = 1'b0;
    signal_in = 4'b0001;
    repeat (4) tick();
    total++;
    if (pulse_out !== 4'h0 || edge_flag !== 4'h0) begin
      bad++;
      $display("FAIL falling_ignores_rise pulse=%b flag=%b expected 0000/0000", pulse_out, edge_flag);
    end
    signal_in[0] = 1'b0;
    for (int k = 1; k <= 7; k++)
      push_exp((k >= 3 && k <= 5) ? 4'b0001 : 4'b0000, (k >= 3) ? 4'b0001 : 4'b0000);
    for (int k = 1; k <= 7; k++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (pulse_out !== e.pulse || edge_flag !== e.flag || pulse_any !== (|e.pulse)) begin
        bad++;
        $display("FAIL falling k=%0d pulse=%b flag=%b any=%b expected pulse=%b flag=%b",
                 k, pulse_out, edge_flag, pulse_any, e.pulse, e.flag);
      end
    end
  endtask

  task automatic test_both_edges();
    exp_t e;
    clear_flags();
    edge_mode = 2'b11;
    extend    = 4'd2;
    signal_in = 4'b0010;
    for (int k = 1; k <= 16; k++)
      push_exp((k == 3 || k == 4 || k == 13 || k == 14) ? 4'b0010 : 4'b0000,
               (k >= 3) ? 4'b0010 : 4'b0000);
    for (int k = 1; k <= 16; k++) begin
      if (k == 11) signal_in[1] = 1'b0;
      tick();
      e = sb.pop_front();
      total++;
      if (pulse_out !== e.pulse || edge_flag !== e.flag || pulse_any !== (|e.pulse)) begin
        bad++;
        $display("FAIL both_edges k=%0d pulse=%b flag=%b any=%b expected pulse=%b flag=%b",
                 k, pulse_out, edge_flag, pulse_any, e.pulse, e.flag);
      end
    end
  endtask

  task automatic test_retrigger();
    exp_t e;
    for (int rt = 1; rt >= 0; rt--) begin
      clear_flags();
      edge_mode = 2'b01;
      extend    = 4'd4;
      retrigger = rt[0];
      for (int k = 1; k <= 10; k++)
        push_exp((k >= 3 && k <= ((rt == 1) ? 8 : 6)) ? 4'b0001 : 4'b0000,
                 (k >= 3) ? 4'b0001 : 4'b0000);
      for (int k = 1; k <= 10; k++) begin
        signal_in[0] = (k != 2);
        if (rt == 0 && k == 4) extend = 4'd9;
        tick();
        e = sb.pop_front();
        total++;
        if (pulse_out !== e.pulse || edge_flag !== e.flag || pulse_any !== (|e.pulse)) begin
          bad++;
          $display("FAIL retrigger%0d k=%0d pulse=%b flag=%b any=%b expected pulse=%b flag=%b",
                   rt, k, pulse_out, edge_flag, pulse_any, e.pulse, e.flag);
        end
      end
      signal_in[0] = 1'b0;
      repeat (4) tick();
    end
    retrigger = 1'b0;
  endtask

  task automatic test_extend_zero_flag();
    exp_t e;
    clear_flags();
    edge_mode = 2'b01;
    extend    = 4'd0;
    for (int k = 1; k <= 5; k++)
      push_exp(4'b0000, (k >= 3) ? 4'b0100 : 4'b0000);
    for (int k = 1; k <= 5; k++) begin
      if (k == 1) signal_in[2] = 1'b1;
      tick();
      e = sb.pop_front();
      total++;
      if (pulse_out !== e.pulse || edge_flag !== e.flag) begin
        bad++;
        $display("FAIL extend_zero k=%0d pulse=%b flag=%b expected pulse=%b flag=%b",
                 k, pulse_out, edge_flag, e.pulse, e.flag);
      end
    end
    flag_clear = 4'b0100;
    tick();
    flag_clear = 4'b0000;
    total++;
    if (edge_flag !== 4'b0000) begin
      bad++;
      $display("FAIL flag_clear flag=%b expected 0000", edge_flag);
    end
    signal_in[2] = 1'b0;
    repeat (3) tick();
    for (int k = 1; k <= 4; k++)
      push_exp(4'b0000, (k >= 3) ? 4'b0100 : 4'b0000);
    for (int k = 1; k <= 4; k++) begin
      if (k == 1) signal_in[2] = 1'b1;
      flag_clear[2] = (k == 3);
      tick();
      e = sb.pop_front();
      total++;
      if (pulse_out !== e.pulse || edge_flag !== e.flag) begin
        bad++;
        $display("FAIL clear_vs_event k=%0d pulse=%b flag=%b expected pulse=%b flag=%b",
                 k, pulse_out, edge_flag, e.pulse, e.flag);
      end
    end
    flag_clear   = 4'b0000;
    signal_in[2] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_pulse();
    exp_t e;
    clear_flags();
    edge_mode    = 2'b01;
    extend       = 4'd5;
    signal_in[0] = 1'b1;
    repeat (3) tick();
    total++;
    if (pulse_out !== 4'b0001 || edge_flag !== 4'b0001) begin
      bad++;
      $display("FAIL pre_reset_pulse pulse=%b flag=%b expected 0001/0001", pulse_out, edge_flag);
    end
    #2;
    rst_n     = 1'b0;
    signal_in = 4'b1000;
    #1;
    total++;
    if (pulse_out !== 4'h0 || pulse_any !== 1'b0 || edge_flag !== 4'h0) begin
      bad++;
      $display("FAIL async_reset pulse=%b any=%b flag=%b expected all zero", pulse_out, pulse_any, edge_flag);
    end
    repeat (2) tick();
    total++;
    if (pulse_out !== 4'h0 || edge_flag !== 4'h0) begin
      bad++;
      $display("FAIL held_reset pulse=%b flag=%b expected 0000/0000", pulse_out, edge_flag);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++)
      push_exp((k >= 3 && k <= 7) ? 4'b1000 : 4'b0000, (k >= 3) ? 4'b1000 : 4'b0000);
    for (int k = 1; k <= 8; k++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (pulse_out !== e.pulse || edge_flag !== e.flag || pulse_any !== (|e.pulse)) begin
        bad++;
        $display("FAIL startup_rise k=%0d pulse=%b flag=%b any=%b expected pulse=%b flag=%b",
                 k, pulse_out, edge_flag, pulse_any, e.pulse, e.flag);
      end
    end
  endtask

  task automatic test_mode_none();
    exp_t e;
    edge_mode = 2'b00;
    clear_flags();
    for (int k = 1; k <= 104; k++) begin
      signal_in = (k <= 100) ? 4'($urandom) : 4'b0000;
      push_exp(4'b0000, 4'b0000);
      tick();
      e = sb.pop_front();
      total++;
      if (pulse_out !== e.pulse || edge_flag !== e.flag) begin
        bad++;
        $display("FAIL mode_none k=%0d pulse=%b flag=%b expected pulse=%b flag=%b",
                 k, pulse_out, edge_flag, e.pulse, e.flag);
      end
    end
    edge_mode = 2'b01;
    for (int k = 1; k <= 10; k++)
      push_exp((k >= 5 && k <= 9) ? 4'b0010 : 4'b0000, (k >= 5) ? 4'b0010 : 4'b0000);
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) signal_in[1] = 1'b1;
      tick();
      e = sb.pop_front();
      total++;
      if (pulse_out !== e.pulse || edge_flag !== e.flag || pulse_any !== (|e.pulse)) begin
        bad++;
        $display("FAIL mode_switch k=%0d pulse=%b flag=%b any=%b expected pulse=%b flag=%b",
                 k, pulse_out, edge_flag, pulse_any, e.pulse, e.flag);
      end
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    signal_in  = 4'h0;
    edge_mode  = 2'b00;
    extend     = 4'd0;
    retrigger  = 1'b0;
    flag_clear = 4'h0;

    test_reset();
    test_falling();
    test_both_edges();
    test_retrigger();
    test_extend_zero_flag();
    test_reset_mid_pulse();
    test_mode_none();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
